// File: rtl/mat_mult_rr_scheduler_if.sv
// Requester-side bus of the shared matrix-multiplier scheduler.
// One valid/ready lane and one operand pair per requester, plus a shared response.
interface mat_mult_rr_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int W       = 512
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_mat_a;
  logic [NUM_REQ*W-1:0] req_mat_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic                 rsp_err;
  logic [W-1:0]         rsp_mat;

  modport master (
    output req_valid,
    output req_mat_a,
    output req_mat_b,
    input  req_ready,
    input  rsp_valid,
    input  rsp_err,
    input  rsp_mat
  );

  modport slave (
    input  req_valid,
    input  req_mat_a,
    input  req_mat_b,
    output req_ready,
    output rsp_valid,
    output rsp_err,
    output rsp_mat
  );
endinterface

// File: rtl/mat_mult_rr_scheduler.sv
// Round-robin front end sharing one complex matrix multiplier.
// Runs one operation at a time and aborts a hung multiplier by watchdog.
module mat_mult_rr_scheduler #(
  parameter int  MAT_N          = 2,
  parameter int  NUM_REQ        = 3,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int W              = 2*64*MAT_N*MAT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  mat_mult_rr_scheduler_if.slave rq,
  output logic                  busy,
  output logic                  mm_valid,
  output logic                  mm_start,
  output logic                  mm_rst,
  output logic [W-1:0]          mm_mat_a,
  output logic [W-1:0]          mm_mat_b,
  input  logic [W-1:0]          mm_mat_out,
  input  logic                  mm_done
);
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RESP,
    ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      id_q, id_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic [W-1:0]       mm_mat_a_q, mm_mat_a_d;
  logic [W-1:0]       mm_mat_b_q, mm_mat_b_d;
  logic [W-1:0]       rsp_mat_q, rsp_mat_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               mm_valid_q, mm_valid_d;
  logic               mm_start_q, mm_start_d;
  logic               abort_q, abort_d;

  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [2*NUM_REQ-1:0] rot_valid;
  logic [IW:0]          win_sum;
  logic [IW-1:0]        win_id;
  logic                 win_found;
  logic [W-1:0]         sel_a;
  logic [W-1:0]         sel_b;
  logic [NUM_REQ-1:0]   id_onehot;
  logic [IW-1:0]        id_next;

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  always_comb begin
    dbl_valid = {rq.req_valid, rq.req_valid};
    rot_valid = dbl_valid >> rr_ptr_q;
    win_found = 1'b0;
    win_sum   = '0;
    win_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_ptr_q} + (IW+1)'(k);
        if (win_sum >= (IW+1)'(NUM_REQ)) begin
          win_sum = win_sum - (IW+1)'(NUM_REQ);
        end
        win_id = win_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == win_id) begin
        sel_a = rq.req_mat_a[k*W +: W];
        sel_b = rq.req_mat_b[k*W +: W];
      end
    end
  end

  assign id_onehot = NUM_REQ'(1) << id_q;
  assign id_next   = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    mm_mat_a_d  = mm_mat_a_q;
    mm_mat_b_d  = mm_mat_b_q;
    rsp_mat_d   = rsp_mat_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = '0;
    mm_valid_d  = 1'b0;
    mm_start_d  = 1'b0;
    abort_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          mm_mat_a_d = sel_a;
          mm_mat_b_d = sel_b;
          id_d       = win_id;
          mm_valid_d = 1'b1;
          mm_start_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        mm_start_d = 1'b1;
        state_d    = START;
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wdog_q != WDW'(TIMEOUT_CYCLES)) begin
          wdog_d = wdog_q + 1'b1;
        end
        // A done arriving on the last watchdog cycle still counts.
        if (mm_done) begin
          rsp_mat_d   = mm_mat_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = id_onehot;
          state_d     = RESP;
        end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          rsp_mat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = id_onehot;
          abort_d     = 1'b1;
          state_d     = ABORT;
        end
      end
      RESP, ABORT: begin
        rr_ptr_d = id_next;
        wdog_d   = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      mm_mat_a_q  <= '0;
      mm_mat_b_q  <= '0;
      rsp_mat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      mm_valid_q  <= 1'b0;
      mm_start_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      mm_mat_a_q  <= mm_mat_a_d;
      mm_mat_b_q  <= mm_mat_b_d;
      rsp_mat_q   <= rsp_mat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      mm_valid_q  <= mm_valid_d;
      mm_start_q  <= mm_start_d;
      abort_q     <= abort_d;
    end
  end

  assign rq.req_ready = (state_q == IDLE && win_found && !rst)
                      ? (NUM_REQ'(1) << win_id) : '0;
  assign rq.rsp_valid = rsp_valid_q;
  assign rq.rsp_err   = rsp_err_q;
  assign rq.rsp_mat   = rsp_mat_q;
  assign busy         = busy_q;
  assign mm_valid     = mm_valid_q;
  assign mm_start     = mm_start_q;
  assign mm_rst       = rst | abort_q;
  assign mm_mat_a     = mm_mat_a_q;
  assign mm_mat_b     = mm_mat_b_q;
endmodule

// File: tb/tb_mat_mult_rr_scheduler.sv
// Bench for mat_mult_rr_scheduler with an a^b multiplier stub.
// Expected grants, latencies and results come from a round-robin model.
module tb_mat_mult_rr_scheduler;
  localparam int MAT_N = 2;
  localparam int NR    = 3;
  localparam int TO    = 8;
  localparam int W     = 2*64*MAT_N*MAT_N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busy, mm_valid, mm_start, mm_rst, mm_done;
  logic [W-1:0] mm_mat_a, mm_mat_b, mm_mat_out;

  int checks = 0;
  int errors = 0;
  int ptr    = 0;
  int delay  = 5;
  bit hang   = 1'b0;
  int st_cnt = 0;
  bit st_act = 1'b0;

  logic [W-1:0] a [NR];
  logic [W-1:0] b [NR];

  mat_mult_rr_scheduler_if #(.NUM_REQ(NR), .W(W)) ifc ();

  mat_mult_rr_scheduler #(
    .MAT_N(MAT_N), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rq(ifc),
    .busy(busy), .mm_valid(mm_valid), .mm_start(mm_start),
    .mm_rst(mm_rst), .mm_mat_a(mm_mat_a), .mm_mat_b(mm_mat_b),
    .mm_mat_out(mm_mat_out), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  // Multiplier stub: done pulses 'delay' cycles after the valid&start cycle.
  always @(posedge clk) begin
    if (mm_rst) begin
      st_act <= 1'b0;
      st_cnt <= 0;
    end else if (mm_valid && mm_start) begin
      st_act <= 1'b1;
      st_cnt <= 1;
    end else if (st_act) begin
      st_cnt <= st_cnt + 1;
      if (mm_done) st_act <= 1'b0;
    end
  end
  assign mm_done    = st_act && !hang && (st_cnt == delay);
  assign mm_mat_out = mm_mat_a ^ mm_mat_b;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_mat();
    logic [W-1:0] v;
    for (int j = 0; j < W/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int rr_pick(input int p, input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++)
      if (m[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      ifc.req_mat_a[i*W +: W] = a[i];
      ifc.req_mat_b[i*W +: W] = b[i];
    end
  endtask

  task automatic run_op(input logic [NR-1:0] mask, input bit hld,
                        input logic [NR-1:0] late, output int gid);
    int win, cyc, lat, rst_cnt;
    bit err, got, rdy_seen;
    logic [W-1:0] ea, eb;
    @(negedge clk);
    chk("idle_busy", W'(busy), W'(0));
    ifc.req_valid = ifc.req_valid | mask;
    #1;
    win = rr_pick(ptr, ifc.req_valid);
    gid = -1;
    for (int k = 0; k < NR; k++) if (ifc.req_ready[k]) gid = k;
    chk("grant", W'(ifc.req_ready), W'(1) << win);
    ea  = a[win];
    eb  = b[win];
    err = hang || (delay > TO + 1);
    lat = err ? TO + 2 : delay + 1;
    @(negedge clk);
    chk("load_valid", W'(mm_valid), W'(1));
    chk("load_start", W'(mm_start), W'(1));
    chk("load_a", mm_mat_a, ea);
    chk("load_b", mm_mat_b, eb);
    if (!hld) ifc.req_valid[win] = 1'b0;
    ifc.req_valid = ifc.req_valid | late;
    a[win] = rnd_mat();
    b[win] = rnd_mat();
    pack();
    cyc = 0; got = 0; rdy_seen = 0; rst_cnt = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("start_valid", W'(mm_valid), W'(0));
        chk("start_start", W'(mm_start), W'(1));
      end
      if (mm_rst) rst_cnt++;
      if (ifc.rsp_valid != 0) got = 1;
      else if (ifc.req_ready != 0) rdy_seen = 1;
    end
    chk("rsp_seen", W'(got), W'(1));
    chk("rsp_lat", W'(cyc), W'(lat));
    chk("rsp_valid", W'(ifc.rsp_valid), W'(1) << win);
    chk("rsp_err", W'(ifc.rsp_err), W'(err));
    chk("rsp_mat", ifc.rsp_mat, err ? '0 : (ea ^ eb));
    chk("mm_rst_pulses", W'(rst_cnt), W'(err));
    chk("no_grant_busy", W'(rdy_seen), W'(0));
    chk("a_stable", mm_mat_a, ea);
    ptr = (win + 1) % NR;
  endtask

  initial begin
    int gid, cnt;
    ifc.req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      a[i] = rnd_mat();
      b[i] = rnd_mat();
    end
    pack();
    repeat (3) @(negedge clk);
    chk("rst_mm_rst", W'(mm_rst), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_ready", W'(ifc.req_ready), W'(0));
    chk("rst_rsp_valid", W'(ifc.rsp_valid), W'(0));
    chk("rst_rsp_mat", ifc.rsp_mat, W'(0));
    chk("rst_mm_valid", W'(mm_valid), W'(0));
    chk("rst_mm_a", mm_mat_a, W'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", W'(ifc.req_ready), W'(0));

    for (int k = 0; k < 6; k++) begin
      run_op(3'b111, 1'b1, 3'b000, gid);
      chk("fair_order", W'(gid), W'(k % NR));
    end
    ifc.req_valid = '0;

    a[0] = {(W/8){8'h11}};
    b[0] = {(W/8){8'h22}};
    pack();
    run_op(3'b001, 1'b0, 3'b000, gid);
    chk("single_mat", ifc.rsp_mat, {(W/8){8'h33}});

    for (int k = 0; k < 5; k++) begin
      delay = $urandom_range(2, TO + 1);
      run_op(NR'($urandom_range(1, 7)), 1'b0, 3'b000, gid);
    end
    ifc.req_valid = '0;

    delay = 5;
    hang  = 1'b1;
    run_op(3'b010, 1'b0, 3'b000, gid);
    hang  = 1'b0;
    run_op(3'b010, 1'b0, 3'b000, gid);

    delay = TO + 1;
    run_op(3'b100, 1'b0, 3'b000, gid);
    delay = 5;
    run_op(3'b001, 1'b0, 3'b100, gid);
    run_op(3'b000, 1'b0, 3'b000, gid);
    chk("late_gid", W'(gid), W'(2));
    ifc.req_valid = '0;
    run_op(3'b010, 1'b0, 3'b000, gid);

    @(negedge clk);
    ifc.req_valid = 3'b100;
    #1;
    chk("rst_op_grant", W'(ifc.req_ready), W'(3'b100));
    @(negedge clk);
    ifc.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_mm_rst", W'(mm_rst), W'(1));
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", W'(busy), W'(0));
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (ifc.rsp_valid != 0) cnt++;
      @(negedge clk);
    end
    chk("mid_rst_no_rsp", W'(cnt), W'(0));
    ptr = 0;
    run_op(3'b110, 1'b0, 3'b000, gid);
    chk("post_rst_gid", W'(gid), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
